// File: rtl/tlb_assoc.sv
// tlb_assoc: fully associative ASID-tagged TLB with permissions, registered lookup, refill and selective flush
module tlb_assoc #(
    parameter int N_ENTRIES  = 16,
    parameter int VA_WIDTH   = 32,
    parameter int PA_WIDTH   = 34,
    parameter int PAGE_BITS  = 12,
    parameter int ASID_WIDTH = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req_valid,
    input  logic [VA_WIDTH-1:0]           i_req_vaddr,
    input  logic [ASID_WIDTH-1:0]         i_req_asid,
    input  logic [1:0]                    i_req_acc,
    input  logic                          i_req_user,
    output logic                          o_resp_valid,
    output logic                          o_resp_hit,
    output logic                          o_resp_miss,
    output logic                          o_resp_fault,
    output logic [PA_WIDTH-1:0]           o_resp_paddr,
    input  logic                          i_fill_valid,
    input  logic [VA_WIDTH-PAGE_BITS-1:0] i_fill_vpn,
    input  logic [PA_WIDTH-PAGE_BITS-1:0] i_fill_ppn,
    input  logic [ASID_WIDTH-1:0]         i_fill_asid,
    input  logic [4:0]                    i_fill_perm,
    input  logic                          i_flush_all,
    input  logic                          i_flush_asid,
    input  logic [ASID_WIDTH-1:0]         i_flush_asid_val
);
    localparam int VPN_W = VA_WIDTH - PAGE_BITS;
    localparam int PPN_W = PA_WIDTH - PAGE_BITS;
    localparam int IDX_W = $clog2(N_ENTRIES);

    logic [N_ENTRIES-1:0]  valid, post_valid;
    logic [VPN_W-1:0]      vpn  [N_ENTRIES];
    logic [PPN_W-1:0]      ppn  [N_ENTRIES];
    logic [ASID_WIDTH-1:0] asid [N_ENTRIES];
    logic [4:0]            perm [N_ENTRIES];
    logic [IDX_W-1:0]      victim, fill_idx;
    logic                  hit_any, allowed, same_found, free_found;
    logic [PPN_W-1:0]      hit_ppn;
    logic [4:0]            hit_perm;

    // Match against pre-update contents; fills keep matches one-hot so OR-merging is exact
    always_comb begin
        hit_any  = 1'b0;
        hit_ppn  = '0;
        hit_perm = '0;
        for (int i = 0; i < N_ENTRIES; i++)
            if (valid[i] && vpn[i] == i_req_vaddr[VA_WIDTH-1:PAGE_BITS] && (perm[i][4] || asid[i] == i_req_asid)) begin
                hit_any  = 1'b1;
                hit_ppn  = hit_ppn | ppn[i];
                hit_perm = hit_perm | perm[i];
            end
        allowed = (i_req_acc == 2'b01 ? hit_perm[1] : i_req_acc == 2'b10 ? hit_perm[2] : hit_perm[0])
                  && (!i_req_user || hit_perm[3]);
    end

    // Apply flushes first, then pick the fill slot: same translation, else lowest free, else victim
    always_comb begin
        same_found = 1'b0;
        free_found = 1'b0;
        fill_idx   = victim;
        for (int i = 0; i < N_ENTRIES; i++)
            post_valid[i] = valid[i] && !i_flush_all && !(i_flush_asid && !perm[i][4] && asid[i] == i_flush_asid_val);
        for (int i = N_ENTRIES - 1; i >= 0; i--)
            if (!post_valid[i]) begin
                free_found = 1'b1;
                fill_idx   = IDX_W'(i);
            end
        for (int i = N_ENTRIES - 1; i >= 0; i--)
            if (post_valid[i] && vpn[i] == i_fill_vpn && (asid[i] == i_fill_asid || perm[i][4] || i_fill_perm[4])) begin
                same_found = 1'b1;
                fill_idx   = IDX_W'(i);
            end
    end

    // Valid bits and round-robin victim pointer, which only moves when a valid entry is evicted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= '0;
            victim <= '0;
        end else begin
            valid <= post_valid;
            if (i_fill_valid)
                valid[fill_idx] <= 1'b1;
            victim <= i_flush_all ? '0 : (i_fill_valid && !same_found && !free_found) ? victim + 1'b1 : victim;
        end
    end

    // Entry payload needs no reset since valid gates every use
    always_ff @(posedge clk) begin
        if (i_fill_valid) begin
            vpn[fill_idx]  <= i_fill_vpn;
            ppn[fill_idx]  <= i_fill_ppn;
            asid[fill_idx] <= i_fill_asid;
            perm[fill_idx] <= i_fill_perm;
        end
    end

    // Registered response, all-zero when no request was presented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_resp_valid <= 1'b0;
            o_resp_hit   <= 1'b0;
            o_resp_miss  <= 1'b0;
            o_resp_fault <= 1'b0;
            o_resp_paddr <= '0;
        end else begin
            o_resp_valid <= i_req_valid;
            o_resp_hit   <= i_req_valid && hit_any && allowed;
            o_resp_miss  <= i_req_valid && !hit_any;
            o_resp_fault <= i_req_valid && hit_any && !allowed;
            o_resp_paddr <= (i_req_valid && hit_any && allowed) ? {hit_ppn, i_req_vaddr[PAGE_BITS-1:0]} : '0;
        end
    end
endmodule

// File: doc/tlb_assoc.md
# tlb_assoc

Fully associative, ASID-tagged translation lookaside buffer with per-entry permissions, registered lookup, refill port and selective flush. It is the next-generation replacement for the single-cycle, FIFO-replaced TLB. It sits between the load/store and fetch address paths and the page-table walker. It reports hit, miss or permission fault per request, so the pipeline can stall for a walk or trap.

## Interface
- N_ENTRIES, 16: number of entries; power of two, ≥2
- VA_WIDTH, 32: virtual address width
- PA_WIDTH, 34: physical address width
- PAGE_BITS, 12: page offset width; VPN = VA_WIDTH-PAGE_BITS, PPN = PA_WIDTH-PAGE_BITS
- ASID_WIDTH, 9: address-space identifier width

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_req_valid  in  1  lookup request
- i_req_vaddr  in  VA_WIDTH  virtual address
- i_req_asid  in  ASID_WIDTH  current ASID
- i_req_acc  in  2  access type: 00 load, 01 store, 10 fetch, 11 reserved (treated as load)
- i_req_user  in  1  request is user mode
- o_resp_valid  out  1  response valid, one cycle after request
- o_resp_hit  out  1  translation found and permitted
- o_resp_miss  out  1  no matching entry
- o_resp_fault  out  1  matching entry, permission denied
- o_resp_paddr  out  PA_WIDTH  {PPN, page offset}; 0 unless hit
- i_fill_valid  in  1  write translation
- i_fill_vpn  in  VA_WIDTH-PAGE_BITS  fill VPN
- i_fill_ppn  in  PA_WIDTH-PAGE_BITS  fill PPN
- i_fill_asid  in  ASID_WIDTH  fill ASID
- i_fill_perm  in  5  {G,U,X,W,R}
- i_flush_all  in  1  invalidate all entries
- i_flush_asid  in  1  invalidate non-global entries of i_flush_asid_val
- i_flush_asid_val  in  ASID_WIDTH  ASID to flush

## Operation
- Entry state: valid, VPN, PPN, ASID, perm[4:0]. Valid bits reset to 0. Victim pointer resets to 0.
- Match: valid && VPN == vaddr[VA_WIDTH-1:PAGE_BITS] && (G || ASID == i_req_asid). Fills guarantee at most one match.
- Permission: load needs R, store needs W, fetch needs X. A user request additionally needs U=1. A supervisor request ignores U.
- Response classes are mutually exclusive:
  - hit: match and permitted; paddr = {PPN, vaddr[PAGE_BITS-1:0]}
  - fault: match and not permitted; paddr = 0
  - miss: no match; paddr = 0
- Fill target, in priority order:
  1. Existing valid entry with same VPN and (same ASID, or either entry G): overwritten in place, no duplicate.
  2. Lowest-index invalid entry.
  3. Entry at the victim pointer, which then increments modulo N_ENTRIES.
- The victim pointer changes only when case 3 is used.
- flush_all: clears all valid bits and resets the victim pointer to 0.
- flush_asid: clears valid on entries with matching ASID and G=0. Global entries and other ASIDs are untouched.
- Same cycle, flush_all and flush_asid: flush_all wins.
- Same cycle, flush and fill: flush applies first, then the fill is written, so the filled entry survives. Its slot is chosen against post-flush valid bits.
- Same cycle, lookup and fill/flush: the lookup sees pre-update contents.

## Timing
- Lookup latency 1 cycle: request at edge N is sampled; the response is registered and visible after edge N, until edge N+1.
- Fully pipelined: one request per cycle, no backpressure.
- Response outputs when i_req_valid=0 in the previous cycle: o_resp_valid=0, hit/miss/fault=0, paddr=0.
- Fill and flush take effect at the clock edge. A lookup issued the next cycle sees the new state.
- Reset: all outputs 0, all entries invalid, victim pointer 0, effective immediately and asynchronously.
- Reset asserted mid-operation discards an in-flight response (o_resp_valid=0 the cycle after release).

## Test plan
- Reset, then load to vaddr 0x0000_1234 with ASID 1 -> next cycle: resp_valid=1, miss=1, paddr=0.
- Fill VPN 0x00001, PPN 0x2ABCD, ASID 1, perm R|W. Load 0x0000_1234 with ASID 1 -> hit, paddr 0x2_ABCD_234. Same load with ASID 2 -> miss. Fetch with ASID 1 -> fault.
- Fill global entry VPN 0x00005, perm G|R|U. User load with ASID 7 -> hit. flush_asid 7 -> still hit. flush_all -> miss.
- Fill 16 distinct VPNs, then a 17th -> entry 0 replaced, victim pointer 1. An 18th -> entry 1 replaced. Refill an existing VPN/ASID -> overwritten in place, pointer unchanged.
- Same-cycle flush_all + fill VPN 0x00009 -> afterwards only VPN 9 hits, in entry 0. Same-cycle lookup of VPN 9 and its fill -> miss, then hit on the following request.
- Assert rst between request and response -> o_resp_valid=0, all entries invalid after release.
